// File: rtl/ext_gpio_pkg.sv
// Shared definitions for the buffered external GPIO controller: direction
// encoding, per-channel direction FSM states and a width helper.
package ext_gpio_pkg;

  localparam logic GPIO_DIR_INPUT  = 1'b1;
  localparam logic GPIO_DIR_OUTPUT = 1'b0;

  typedef enum logic [1:0] {
    ST_IN     = 2'd0,
    ST_IN2OUT = 2'd1,
    ST_OUT    = 2'd2,
    ST_OUT2IN = 2'd3
  } gpio_state_e;

  // Ceiling log2, never narrower than one bit so counters always exist.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ext_gpio_chan.sv
// One buffered GPIO channel: synchroniser, optional debounce filter
// (EXT_GPIO_DEBOUNCE_EN), edge interrupts, drive logic and direction turnaround.
module ext_gpio_chan
  import ext_gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int GUARD_CYCLES    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_dir,
  input  logic cfg_oc,
  input  logic cfg_out,
  input  logic cfg_rise_ie,
  input  logic cfg_fall_ie,
  input  logic irq_clr,
  input  logic gpio_i,
  output logic gpio_o,
  output logic gpio_t,
  output logic buf_dir,
  output logic buf_oc,
  output logic gpio_in_val,
  output logic irq_status,
  output logic dir_busy
);

  localparam int GW = clog2(GUARD_CYCLES + 1);

  gpio_state_e      state, state_nxt;
  logic [GW-1:0]    gcnt, gcnt_nxt;
  logic             gpio_o_nxt, gpio_t_nxt, buf_dir_nxt;
  logic             drive_o, drive_t;
  logic [SYNC_STAGES-1:0] sync;
  logic             synced;
  logic             in_val_nxt;
  logic             val_d;
  logic             entering_in;
  logic             edge_set;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], gpio_i};
  end

`ifdef EXT_GPIO_DEBOUNCE_EN
  localparam int DB_W = clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt, db_cnt_nxt;

  // A new level is accepted only after it has been stable for the full window.
  always_comb begin
    db_cnt_nxt = '0;
    in_val_nxt = gpio_in_val;
    if (synced != gpio_in_val) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) in_val_nxt = synced;
      else                                      db_cnt_nxt = db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      gpio_in_val <= 1'b0;
    end else begin
      db_cnt      <= db_cnt_nxt;
      gpio_in_val <= in_val_nxt;
    end
  end
`else
  assign gpio_in_val = synced;
  assign in_val_nxt  = sync[SYNC_STAGES-2];
`endif

  assign drive_o = cfg_oc ? 1'b0 : cfg_out;
  assign drive_t = cfg_oc ? cfg_out : 1'b0;

  always_comb begin
    state_nxt   = state;
    gcnt_nxt    = gcnt;
    gpio_o_nxt  = gpio_o;
    gpio_t_nxt  = gpio_t;
    buf_dir_nxt = buf_dir;
    case (state)
      ST_IN: begin
        gpio_o_nxt  = 1'b0;
        gpio_t_nxt  = 1'b1;
        buf_dir_nxt = GPIO_DIR_INPUT;
        if (cfg_dir == GPIO_DIR_OUTPUT) begin
          state_nxt   = ST_IN2OUT;
          buf_dir_nxt = GPIO_DIR_OUTPUT;
          gcnt_nxt    = '0;
        end
      end
      ST_IN2OUT: begin
        if (gcnt == GW'(GUARD_CYCLES - 1)) begin
          state_nxt  = ST_OUT;
          gpio_o_nxt = drive_o;
          gpio_t_nxt = drive_t;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      ST_OUT: begin
        if (cfg_dir == GPIO_DIR_INPUT) begin
          // Release the pin first; the buffer flips only after the guard time.
          state_nxt  = ST_OUT2IN;
          gpio_o_nxt = 1'b0;
          gpio_t_nxt = 1'b1;
          gcnt_nxt   = '0;
        end else begin
          gpio_o_nxt = drive_o;
          gpio_t_nxt = drive_t;
        end
      end
      ST_OUT2IN: begin
        if (gcnt == GW'(GUARD_CYCLES - 1)) begin
          state_nxt   = ST_IN;
          buf_dir_nxt = GPIO_DIR_INPUT;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      default: state_nxt = ST_IN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IN;
      gcnt     <= '0;
      gpio_o   <= 1'b0;
      gpio_t   <= 1'b1;
      buf_dir  <= GPIO_DIR_INPUT;
      buf_oc   <= 1'b1;
      dir_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      gcnt     <= gcnt_nxt;
      gpio_o   <= gpio_o_nxt;
      gpio_t   <= gpio_t_nxt;
      buf_dir  <= buf_dir_nxt;
      buf_oc   <= cfg_oc;
      dir_busy <= (state_nxt == ST_IN2OUT) || (state_nxt == ST_OUT2IN);
    end
  end

  // Reloading the delayed copy on entry to IN hides level changes seen while driving.
  assign entering_in = (state != ST_IN) && (state_nxt == ST_IN);
  assign edge_set    = (state == ST_IN) &&
                       ((gpio_in_val && !val_d && cfg_rise_ie) ||
                        (!gpio_in_val && val_d && cfg_fall_ie));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_d      <= 1'b0;
      irq_status <= 1'b0;
    end else begin
      val_d      <= entering_in ? in_val_nxt : gpio_in_val;
      irq_status <= edge_set || (irq_status && !irq_clr);
    end
  end

endmodule

// File: rtl/ext_gpio_ctrl.sv
// N-channel buffered external GPIO controller; debounce is enabled by
// defining EXT_GPIO_DEBOUNCE_EN.
module ext_gpio_ctrl
  import ext_gpio_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int GUARD_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] cfg_dir,
  input  logic [NUM_CH-1:0] cfg_oc,
  input  logic [NUM_CH-1:0] cfg_out,
  input  logic [NUM_CH-1:0] cfg_rise_ie,
  input  logic [NUM_CH-1:0] cfg_fall_ie,
  input  logic [NUM_CH-1:0] irq_clr,
  input  logic [NUM_CH-1:0] gpio_i,
  output logic [NUM_CH-1:0] gpio_o,
  output logic [NUM_CH-1:0] gpio_t,
  output logic [NUM_CH-1:0] buf_dir,
  output logic [NUM_CH-1:0] buf_oc,
  output logic [NUM_CH-1:0] gpio_in_val,
  output logic [NUM_CH-1:0] irq_status,
  output logic [NUM_CH-1:0] dir_busy,
  output logic              irq
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ext_gpio_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .GUARD_CYCLES   (GUARD_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .cfg_dir    (cfg_dir[i]),
      .cfg_oc     (cfg_oc[i]),
      .cfg_out    (cfg_out[i]),
      .cfg_rise_ie(cfg_rise_ie[i]),
      .cfg_fall_ie(cfg_fall_ie[i]),
      .irq_clr    (irq_clr[i]),
      .gpio_i     (gpio_i[i]),
      .gpio_o     (gpio_o[i]),
      .gpio_t     (gpio_t[i]),
      .buf_dir    (buf_dir[i]),
      .buf_oc     (buf_oc[i]),
      .gpio_in_val(gpio_in_val[i]),
      .irq_status (irq_status[i]),
      .dir_busy   (dir_busy[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |irq_status;
  end

endmodule

// File: doc/ext_gpio_ctrl.md
Name: ext_gpio_ctrl

Overview:
- Parametrised N-channel controller for buffered external GPIOs: bidirectional pin with external level-shift buffer (dir + open-collector controls).
- Successor to the fixed, hard-tied ext_gpio pins of the board top level; sits between SoC register logic and the pin IOBUFs.
- Per channel: input synchronisation, debounce, rise/fall interrupts with sticky status, open-drain emulation, glitch-free direction turnaround sequencing pin tristate against buffer direction.

Parameters:
NUM_CH, 2, number of channels (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a new input level (>=1)
GUARD_CYCLES, 4, dead cycles between pin tristate change and buffer direction change (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_dir  in  NUM_CH  requested direction, 1=input, 0=output (GPIO_DIR_INPUT/OUTPUT)
cfg_oc  in  NUM_CH  1=open-collector drive, 0=push-pull
cfg_out  in  NUM_CH  output level request
cfg_rise_ie  in  NUM_CH  rising-edge interrupt enable
cfg_fall_ie  in  NUM_CH  falling-edge interrupt enable
irq_clr  in  NUM_CH  write-1-to-clear pulse for irq_status
gpio_i  in  NUM_CH  pin value from IOBUF O
gpio_o  out  NUM_CH  to IOBUF I
gpio_t  out  NUM_CH  to IOBUF T, 1=tristate
buf_dir  out  NUM_CH  external buffer direction
buf_oc  out  NUM_CH  external buffer open-collector enable
gpio_in_val  out  NUM_CH  filtered input level
irq_status  out  NUM_CH  sticky edge flags
dir_busy  out  NUM_CH  1 while a turnaround is in progress
irq  out  1  registered OR of irq_status

Behaviour:
- Reset (async, rst=1), all registered: gpio_o=0, gpio_t=all 1, buf_dir=all GPIO_DIR_INPUT(1), buf_oc=all 1, gpio_in_val=0, irq_status=0, dir_busy=0, irq=0. Channel FSM=IN, all counters 0, synchroniser flops 0. Reset mid-turnaround or mid-debounce aborts immediately to these values.
- Per-channel direction FSM, states IN, IN2OUT, OUT, OUT2IN:
  - IN: gpio_t=1, buf_dir=1. cfg_dir=0 -> IN2OUT, buf_dir<=0, guard counter cleared.
  - IN2OUT: gpio_t stays 1 for GUARD_CYCLES cycles -> OUT.
  - OUT: gpio_t/gpio_o driven per the drive rule below. cfg_dir=1 -> OUT2IN, gpio_t<=1 in that same transition.
  - OUT2IN: after GUARD_CYCLES cycles -> IN, buf_dir<=1.
  - dir_busy=1 in IN2OUT/OUT2IN.
  - cfg_dir changes during a transit state are ignored until the transit completes, then re-evaluated the next cycle.
- Drive rule (OUT only, registered, 1-cycle latency from cfg_out/cfg_oc):
  - Push-pull: gpio_o=cfg_out, gpio_t=0.
  - Open-collector: gpio_o=0, gpio_t=cfg_out (1 releases the pin).
  - buf_oc follows cfg_oc with 1-cycle latency in every state.
- Input path: SYNC_STAGES-flop synchroniser, then debounce filter, giving gpio_in_val.
  - Debounce counter width clog2(DEBOUNCE_CYCLES+1).
  - Counts while synced != gpio_in_val; clears when equal.
  - On reaching DEBOUNCE_CYCLES, gpio_in_val toggles and the counter clears.
  - Step-to-gpio_in_val latency = SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Edge detect on gpio_in_val versus its 1-cycle delayed copy, qualified by state==IN.
  - Rise with cfg_rise_ie, or fall with cfg_fall_ie, sets irq_status 1 cycle after the gpio_in_val change.
  - On entry to IN, the delayed copy reloads so no spurious edge is reported.
- irq_status is sticky; irq_clr clears it. Set and clear in the same cycle: set wins (status stays 1).
- irq = OR(irq_status), registered, +1 cycle.

Optional Feature:
- EXT_GPIO_DEBOUNCE_EN defined: debounce filter as above.
- Undefined: filter and counters removed; gpio_in_val = synchroniser output, latency SYNC_STAGES; DEBOUNCE_CYCLES unused.

Decomposition:
- Package ext_gpio_pkg holds GPIO_DIR_INPUT=1'b1, GPIO_DIR_OUTPUT=1'b0, FSM state encoding (2-bit: IN, IN2OUT, OUT, OUT2IN), and a clog2 helper function.
- Sub-module ext_gpio_chan implements one channel (sync, filter, edge, FSM, drive).
- Top instantiates NUM_CH copies via generate and adds the irq OR register.

Test Plan:
- Reset: assert rst mid-OUT2IN -> all outputs take their reset values in the same cycle without a clock edge; gpio_t=1 and buf_dir=1 on every channel.
- IN->OUT, GUARD_CYCLES=4: cfg_dir 1->0 -> buf_dir=0 next cycle, gpio_t stays 1 for 4 cycles, then 0 with gpio_o=cfg_out. OUT->IN: gpio_t=1 first, buf_dir=1 4 cycles later. dir_busy high throughout; at no cycle is gpio_t=0 while buf_dir=1.
- Debounce, DEBOUNCE_CYCLES=8: gpio_i pulses 5 cycles high -> no change. Held high -> gpio_in_val=1 after 10 cycles, irq_status=1 at 11, irq=1 at 12 with rise_ie=1.
- Open-collector: cfg_oc=1 in OUT, cfg_out 0->1 -> gpio_o stays 0, gpio_t 0->1 one cycle later; buf_oc=1.
- Interrupt race: irq_clr pulse in the same cycle as a new qualifying fall edge -> irq_status stays 1; a lone irq_clr next cycle clears it and irq drops 1 cycle later.
- EXT_GPIO_DEBOUNCE_EN undefined: gpio_i step -> gpio_in_val follows after exactly SYNC_STAGES=2 cycles; a 1-cycle glitch is reported as an edge.
